mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between two requesters:
  - the LC-3 controller/datapath (core port), covering instruction fetch, indirect address read, read memory and write memory;
  - an external/debug loader port (ext port).
- Drives the memory enable, write, address and data lines, and counts fixed memory wait states.
- Returns read data and produces the one-cycle `complete` pulse that the controller FSM waits on in its fetch and memory states.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 2, cycles the memory access is held active; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; level, sampled only in IDLE.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_din  in  DATA_W  core write data.
- core_dout  out  DATA_W  registered core read data.
- complete  out  1  one-cycle pulse when a core access finishes.
- ext_req  in  1  external access request; level.
- ext_we  in  1  external write enable.
- ext_addr  in  ADDR_W  external address.
- ext_din  in  DATA_W  external write data.
- ext_dout  out  DATA_W  registered external read data.
- ext_done  out  1  one-cycle pulse when an external access finishes.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid by the last ACCESS cycle.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  0 = core, 1 = ext; the port granted the current or most recent access.

Behaviour:
- Reset values:
  - state = IDLE;
  - all outputs 0, including core_dout and ext_dout;
  - last_grant = 1 (ext), so the core wins the first tie;
  - wait counter = 0.
- States:
  - IDLE: if a request is present, latch the winner's we/addr/din into internal registers, set owner, load counter = WAIT_CYCLES-1, go to ACCESS; otherwise stay in IDLE.
  - ACCESS:
    - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata come from the latched registers.
    - The counter decrements each cycle.
    - When counter = 0: on a read, capture mem_rdata into the owner's dout register; go to DONE.
  - DONE:
    - mem_en = 0.
    - Pulse `complete` (owner = 0) or `ext_done` (owner = 1) for exactly this one cycle.
    - Update last_grant = owner; go to IDLE.
- Latency:
  - A request seen at edge E gives ACCESS during the WAIT_CYCLES cycles after E, then a DONE pulse in cycle WAIT_CYCLES+1 after E.
  - Back-to-back accesses have one IDLE cycle between them (period WAIT_CYCLES+2).
- Latching: latched we/addr/din are frozen for the whole access. Changes on requester inputs after grant are ignored.
- Arbitration:
  - Requests are evaluated only in IDLE.
  - Single requester: it wins.
  - Both requesting: round-robin; the port that is not last_grant wins.
  - A held request that was not granted stays pending with no timeout.
- Data outputs:
  - Writes leave core_dout/ext_dout unchanged.
  - Each dout register holds its value until that port's next read completes.
- Re-request: a request still high in the IDLE cycle after DONE is treated as a new access. This supports controller sequences such as indirect read followed by read memory.
- Reset mid-access: return to IDLE next edge and drop mem_en. No done pulse, and the access is abandoned.
- Outputs are registered or state-decoded; no combinational path from inputs to mem_* outputs.

Optional Feature:
- Macro: CORE_PRIORITY_EN.
- Defined: fixed priority. The core always wins when both ports request; last_grant is ignored for arbitration but still updated. Ext can starve while the core requests continuously.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Reset, then core_req=1, core_we=0, core_addr=16'h3000, mem_rdata=16'h1234 (WAIT_CYCLES=2):
   - mem_en high 2 cycles with mem_addr=16'h3000;
   - complete high exactly the 3rd cycle after the request edge;
   - core_dout=16'h1234; ext_done stays 0.
2. ext_req=1, ext_we=1, ext_addr=16'h0040, ext_din=16'hBEEF:
   - mem_we=1 and mem_wdata=16'hBEEF for 2 cycles; ext_done pulses once;
   - ext_dout and core_dout unchanged; owner=1.
3. core_req and ext_req both held high from reset:
   - grants alternate core, ext, core, ext;
   - DONE pulses every 4 cycles;
   - with CORE_PRIORITY_EN, only complete pulses and ext_done stays 0.
4. Change core_addr from 16'h3000 to 16'h4000 during ACCESS: mem_addr stays 16'h3000 for the whole access.
5. Assert reset during the 2nd ACCESS cycle:
   - next cycle mem_en=0, busy=0, core_dout=0;
   - no complete pulse;
   - the next core request is granted first, before ext.
6. Core read at 16'h3000 (data 16'h0200), core_req held, addr changed to 16'h0200 during DONE (data 16'h5555):
   - second access starts after one IDLE cycle;
   - core_dout=16'h5555; complete pulses twice, 4 cycles apart.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between the LC-3 core and an external loader.
// Optional macro CORE_PRIORITY_EN: core always wins ties (default build is round-robin).
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic [DATA_W-1:0] core_dout,
  output logic              complete,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_din,
  output logic [DATA_W-1:0] ext_dout,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  count_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic              req_any;
  logic              pick_ext;
  logic              capture;

  always_comb begin
    req_any = core_req | ext_req;
`ifdef CORE_PRIORITY_EN
    pick_ext = ext_req & ~core_req;
`else
    // On a tie the port that did not hold the previous grant goes next.
    pick_ext = ext_req & (~core_req | ~last_grant_reg);
`endif
  end

  assign capture = (state_reg == ACCESS) && (count_reg == '0) && !we_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = ACCESS;
      ACCESS:  if (count_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg      <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      din_reg        <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            owner_reg <= pick_ext;
            count_reg <= CNT_LOAD;
            we_reg    <= pick_ext ? ext_we   : core_we;
            addr_reg  <= pick_ext ? ext_addr : core_addr;
            din_reg   <= pick_ext ? ext_din  : core_din;
          end
        end
        ACCESS: begin
          if (count_reg != '0) count_reg <= count_reg - CNT_W'(1);
        end
        DONE: begin
          last_grant_reg <= owner_reg;
        end
        default: ;
      endcase
    end
  end

  // Index 0 holds the core read-data register, index 1 the external one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dout
      logic [DATA_W-1:0] dout_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          dout_reg <= '0;
        end else if (capture && (owner_reg == 1'(gi))) begin
          dout_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  assign core_dout = g_dout[0].dout_reg;
  assign ext_dout  = g_dout[1].dout_reg;
  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == ACCESS);
  assign mem_we    = (state_reg == ACCESS) & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = din_reg;
  assign complete  = (state_reg == DONE) & ~owner_reg;
  assign ext_done  = (state_reg == DONE) & owner_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and random traffic against an interval-based transaction model.
module tb_mem_port_arbiter;

  localparam int W = 2;
`ifdef CORE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, ext_req, ext_we;
  logic [15:0] core_addr, core_din, ext_addr, ext_din;
  logic [15:0] core_dout, ext_dout, mem_addr, mem_wdata, mem_rdata;
  logic        complete, ext_done, mem_en, mem_we, busy, owner;

  logic [15:0] mem [0:65535];
  int errors = 0;
  int checks = 0;

  // Transaction model state
  bit          model_on = 1'b0;
  int          m_edge = 0;
  int          m_n = 0;
  int          m_next = 0;
  bit          m_active = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_own_out = 1'b0;
  bit          m_we = 1'b0;
  bit          m_last = 1'b1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_din = '0;
  logic [15:0] m_cd = '0;
  logic [15:0] m_ed = '0;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [15:0] c_din;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_din;
    logic        x_owner;
    logic        x_we;
    logic [15:0] x_addr;
    logic [15:0] x_wdata;
    logic [15:0] x_cdout;
    logic [15:0] x_edout;
  } vec_t;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_dout(core_dout), .complete(complete),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_dout(ext_dout), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit ext_wins;
    m_edge++;
    if (reset) begin
      m_active  = 1'b0;
      m_last    = 1'b1;
      m_cd      = '0;
      m_ed      = '0;
      m_own_out = 1'b0;
      m_next    = m_edge + 1;
    end else begin
      if (m_active && m_edge == m_n + W && !m_we) begin
        if (m_owner) m_ed = mem[m_addr];
        else         m_cd = mem[m_addr];
      end
      if (m_active && m_edge == m_n + W + 1) begin
        m_active = 1'b0;
        m_last   = m_owner;
      end
      if (!m_active && m_edge >= m_next && (core_req || ext_req)) begin
        ext_wins  = ext_req && (!core_req || (!PRIO && !m_last));
        m_active  = 1'b1;
        m_n       = m_edge;
        m_next    = m_edge + W + 2;
        m_owner   = ext_wins;
        m_own_out = ext_wins;
        m_we      = ext_wins ? ext_we   : core_we;
        m_addr    = ext_wins ? ext_addr : core_addr;
        m_din     = ext_wins ? ext_din  : core_din;
      end
    end
  endtask

  task automatic model_check();
    bit acc;
    bit dn;
    acc = m_active && (m_edge >= m_n) && (m_edge < m_n + W);
    dn  = m_active && (m_edge == m_n + W);
    chk("rnd mem_en", mem_en, acc);
    chk("rnd mem_we", mem_we, acc && m_we);
    chk("rnd busy", busy, acc || dn);
    chk("rnd complete", complete, dn && !m_owner);
    chk("rnd ext_done", ext_done, dn && m_owner);
    chk("rnd owner", owner, m_own_out);
    chk("rnd core_dout", core_dout, m_cd);
    chk("rnd ext_dout", ext_dout, m_ed);
    if (acc) begin
      chk("rnd mem_addr", mem_addr, m_addr);
      if (m_we) chk("rnd mem_wdata", mem_wdata, m_din);
    end
  endtask

  // One clock: model sees the edge, then memory and checks act at the falling edge.
  task automatic step();
    @(posedge clock);
    if (model_on) model_edge();
    @(negedge clock);
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata = mem[mem_addr];
    if (model_on) model_check();
  endtask

  task automatic run_vec(input int k, input vec_t v);
    core_req = v.c_req; core_we = v.c_we; core_addr = v.c_addr; core_din = v.c_din;
    ext_req  = v.e_req; ext_we  = v.e_we; ext_addr  = v.e_addr; ext_din  = v.e_din;
    step();
    core_req = 1'b0;
    ext_req  = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) step();
      chk($sformatf("v%0d mem_en", k), mem_en, 1'b1);
      chk($sformatf("v%0d mem_we", k), mem_we, v.x_we);
      chk($sformatf("v%0d mem_addr", k), mem_addr, v.x_addr);
      if (v.x_we) chk($sformatf("v%0d mem_wdata", k), mem_wdata, v.x_wdata);
      chk($sformatf("v%0d owner", k), owner, v.x_owner);
      chk($sformatf("v%0d early pulse", k), complete | ext_done, 1'b0);
    end
    step();
    chk($sformatf("v%0d done mem_en", k), mem_en, 1'b0);
    chk($sformatf("v%0d complete", k), complete, !v.x_owner);
    chk($sformatf("v%0d ext_done", k), ext_done, v.x_owner);
    chk($sformatf("v%0d core_dout", k), core_dout, v.x_cdout);
    chk($sformatf("v%0d ext_dout", k), ext_dout, v.x_edout);
    step();
    chk($sformatf("v%0d idle busy", k), busy, 1'b0);
    chk($sformatf("v%0d idle pulse", k), complete | ext_done, 1'b0);
    $display("vector %0d: owner=%0d we=%0d addr=%h core_dout=%h ext_dout=%h",
             k, owner, v.x_we, v.x_addr, core_dout, ext_dout);
  endtask

  initial begin
    vec_t vt [9];
    logic exp_c;
    logic exp_e;

    vt[0] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF,
              1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h1234, 16'h0000};
    vt[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
              1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 16'hBEEF};
    vt[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h3000, 16'h0000,
              1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF};
    vt[4] = '{1'b1, 1'b1, 16'h0100, 16'h1111, 1'b1, 1'b0, 16'h3000, 16'h0000,
              PRIO ? 1'b0 : 1'b1, PRIO ? 1'b1 : 1'b0, PRIO ? 16'h0100 : 16'h3000,
              PRIO ? 16'h1111 : 16'h0000, 16'hBEEF, PRIO ? 16'hBEEF : 16'h1234};
    vt[5] = '{1'b1, 1'b1, 16'h0100, 16'hCAFE, 1'b1, 1'b1, 16'h0200, 16'h7777,
              1'b0, 1'b1, 16'h0100, 16'hCAFE, 16'hBEEF, PRIO ? 16'hBEEF : 16'h1234};
    vt[6] = '{1'b1, 1'b1, 16'h0300, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 16'h0000,
              1'b0, 1'b1, 16'h0300, 16'hA5A5, 16'hBEEF, PRIO ? 16'hBEEF : 16'h1234};
    vt[7] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, PRIO ? 16'hBEEF : 16'h1234};
    vt[8] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000,
              PRIO ? 1'b0 : 1'b1, 1'b0, PRIO ? 16'h0300 : 16'h0100, 16'h0000,
              PRIO ? 16'hA5A5 : 16'hCAFE, PRIO ? 16'hBEEF : 16'hCAFE};

    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_din = '0;
    ext_req  = 1'b0; ext_we  = 1'b0; ext_addr  = '0; ext_din  = '0;
    mem_rdata = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h3000] = 16'h1234;
    mem[16'h4000] = 16'h9999;

    step();
    step();
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst mem_wdata", mem_wdata, 16'h0000);
    chk("rst busy", busy, 1'b0);
    chk("rst owner", owner, 1'b0);
    chk("rst pulses", complete | ext_done, 1'b0);
    chk("rst core_dout", core_dout, 16'h0000);
    chk("rst ext_dout", ext_dout, 16'h0000);
    reset = 1'b0;
    step();
    chk("idle busy", busy, 1'b0);
    $display("reset: busy=%0d mem_en=%0d owner=%0d", busy, mem_en, owner);

    for (int k = 0; k < 9; k++) run_vec(k, vt[k]);

    // Address change mid-access must not reach mem_addr.
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h3000;
    step();
    core_addr = 16'h4000;
    core_req  = 1'b0;
    chk("latch addr c1", mem_addr, 16'h3000);
    step();
    chk("latch addr c2", mem_addr, 16'h3000);
    step();
    chk("latch complete", complete, 1'b1);
    chk("latch core_dout", core_dout, 16'h1234);
    step();
    $display("latch: core_dout=%h", core_dout);

    // Reset during the second access cycle abandons the access.
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0040;
    step();
    step();
    chk("midrst in access", mem_en, 1'b1);
    reset = 1'b1;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h3000;
    step();
    chk("midrst mem_en", mem_en, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst core_dout", core_dout, 16'h0000);
    chk("midrst pulses", complete | ext_done, 1'b0);
    reset = 1'b0;
    step();
    chk("midrst regrant owner", owner, 1'b0);
    chk("midrst regrant addr", mem_addr, 16'h0040);
    core_req = 1'b0;
    ext_req  = 1'b0;
    step();
    step();
    chk("midrst complete", complete, 1'b1);
    chk("midrst core_dout2", core_dout, 16'hBEEF);
    step();
    $display("reset mid-access: core_dout=%h owner=%0d", core_dout, owner);

    // Held core request re-issues after one IDLE cycle with the new address.
    mem[16'h3000] = 16'h0200;
    mem[16'h0200] = 16'h5555;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h3000;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("rereq c%0d complete", c), complete, (c == 3) || (c == 7));
      chk($sformatf("rereq c%0d mem_en", c), mem_en, (c == 1) || (c == 2) || (c == 5) || (c == 6));
      if (c == 1 || c == 2) chk($sformatf("rereq c%0d addr", c), mem_addr, 16'h3000);
      if (c == 5 || c == 6) chk($sformatf("rereq c%0d addr", c), mem_addr, 16'h0200);
      if (c == 3) begin
        chk("rereq first dout", core_dout, 16'h0200);
        core_addr = 16'h0200;
      end
      if (c == 5) core_req = 1'b0;
    end
    chk("rereq second dout", core_dout, 16'h5555);
    $display("re-request: core_dout=%h", core_dout);

    // Both ports held from reset: grant order and pulse spacing.
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h3000;
    ext_req  = 1'b1; ext_we  = 1'b0; ext_addr  = 16'h0040;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_c = (c % 4 == 3) && (PRIO || ((c / 4) % 2 == 0));
      exp_e = (c % 4 == 3) && !PRIO && ((c / 4) % 2 == 1);
      chk($sformatf("both c%0d complete", c), complete, exp_c);
      chk($sformatf("both c%0d ext_done", c), ext_done, exp_e);
      if (c % 4 == 1) chk($sformatf("both c%0d owner", c), owner, !PRIO && ((c / 4) % 2 == 1));
    end
    $display("both held: core_dout=%h ext_dout=%h", core_dout, ext_dout);

    // Random traffic against the transaction model.
    reset = 1'b1;
    core_req = 1'b0;
    ext_req  = 1'b0;
    model_on = 1'b1;
    step();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      core_req  = ($urandom_range(0, 3) != 0);
      core_we   = 1'($urandom_range(0, 1));
      core_addr = 16'($urandom_range(0, 15));
      core_din  = 16'($urandom);
      ext_req   = ($urandom_range(0, 3) != 0);
      ext_we    = 1'($urandom_range(0, 1));
      ext_addr  = 16'($urandom_range(0, 15));
      ext_din   = 16'($urandom);
      step();
    end
    $display("random: %0d cycles, core_dout=%h ext_dout=%h", 3000, core_dout, ext_dout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
